// File: rtl/peripheral_arbiter_wb.sv
// ============================================================================
// peripheral_arbiter_wb
// ----------------------------------------------------------------------------
// Round-robin Wishbone B3 arbiter. It shares one slave port among
// NUM_MASTERS masters. The owner keeps the grant for its whole cyc cycle,
// whether classic or CTI burst. The arbiter never inspects cti and never
// preempts an owner. A bus watchdog aborts an owner whose strobe waits too
// long for a termination; the owner then receives err.
//
// Parameters
//   AW          address width
//   DW          data width (byte-select width DW/8)
//   NUM_MASTERS number of requesters (>= 2)
//   TIMEOUT     max stb cycles without ack/err/rty before abort, 0 = off
//
// Ports
//   wb_clk_i, wb_rst_ni          clock (rising edge), async active-low reset
//   m_adr_i/m_dat_i/m_sel_i      packed per-master address/data/select,
//                                master k at [k*W +: W]
//   m_we_i/m_cyc_i/m_stb_i       per-master we/cyc/stb
//   m_cti_i/m_bte_i              per-master cycle type / burst type
//   m_dat_o                      slave read data broadcast to every master
//   m_ack_o/m_err_o/m_rty_o      per-master terminations (owner only)
//   s_*_o                        slave-side request signals (owner's, muxed)
//   s_dat_i, s_ack_i/err_i/rty_i slave read data and terminations
//   grant_o                      registered one-hot owner, 0 when idle
//   timeout_o                    one-cycle pulse when the watchdog aborts
// ============================================================================
module peripheral_arbiter_wb #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int NUM_MASTERS = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_ni,
   // master side
   input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
   input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
   input  logic [NUM_MASTERS-1:0]      m_we_i,
   input  logic [NUM_MASTERS-1:0]      m_cyc_i,
   input  logic [NUM_MASTERS-1:0]      m_stb_i,
   input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
   input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
   output logic [DW-1:0]               m_dat_o,
   output logic [NUM_MASTERS-1:0]      m_ack_o,
   output logic [NUM_MASTERS-1:0]      m_err_o,
   output logic [NUM_MASTERS-1:0]      m_rty_o,
   // slave side
   output logic [AW-1:0]               s_adr_o,
   output logic [DW-1:0]               s_dat_o,
   output logic [DW/8-1:0]             s_sel_o,
   output logic                        s_we_o,
   output logic                        s_cyc_o,
   output logic                        s_stb_o,
   output logic [2:0]                  s_cti_o,
   output logic [1:0]                  s_bte_o,
   input  logic [DW-1:0]               s_dat_i,
   input  logic                        s_ack_i,
   input  logic                        s_err_i,
   input  logic                        s_rty_i,
   // status
   output logic [NUM_MASTERS-1:0]      grant_o,
   output logic                        timeout_o
);

   localparam int N         = NUM_MASTERS;
   localparam int SW        = DW / 8;
   localparam int PW        = (N > 1) ? $clog2(N) : 1;
   localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] WD_LAST = CW'(WD_LAST_I);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [PW-1:0] owner_q, owner_d;   // index of the granted master
   logic [PW-1:0] last_q, last_d;     // previous owner, round-robin origin
   logic [CW-1:0] wd_q, wd_d;
   logic          err_pend_q, err_pend_d;

   logic [PW-1:0] pick;
   logic          pick_vld;
   logic          in_grant;
   logic          cyc_g;
   logic          stb_g;
   logic          term_any;

   // ------------------------------------------------------------------
   // Round-robin pick: first requester after the previous owner, wrapping.
   // Only cyc is considered; a master with cyc but no stb still wins.
   // ------------------------------------------------------------------
   always_comb begin
      int            idx;
      logic [PW-1:0] idx_b;
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      idx_b    = '0;
      for (int i = 1; i <= N; i++) begin
         idx   = (int'(last_q) + i) % N;
         idx_b = PW'(idx);
         if (!pick_vld && m_cyc_i[idx_b]) begin
            pick_vld = 1'b1;
            pick     = idx_b;
         end
      end
   end

   assign in_grant = (state_q == ST_GRANT);
   assign cyc_g    = m_cyc_i[owner_q];
   assign stb_g    = m_stb_i[owner_q] & cyc_g;
   assign term_any = s_ack_i | s_err_i | s_rty_i;

   // ------------------------------------------------------------------
   // Slave-side mux. Everything is forced to 0 outside GRANT, so reset
   // (which clears the state asynchronously) drops cyc/stb at once and an
   // aborted owner no longer reaches the slave.
   // ------------------------------------------------------------------
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_cti_o = '0;
      s_bte_o = '0;
      if (in_grant) begin
         s_adr_o = m_adr_i[int'(owner_q)*AW +: AW];
         s_dat_o = m_dat_i[int'(owner_q)*DW +: DW];
         s_sel_o = m_sel_i[int'(owner_q)*SW +: SW];
         s_we_o  = m_we_i[owner_q];
         s_cyc_o = cyc_g;
         s_stb_o = stb_g;
         s_cti_o = m_cti_i[int'(owner_q)*3 +: 3];
         s_bte_o = m_bte_i[int'(owner_q)*2 +: 2];
      end
   end

   // Terminations reach only the owner. A late ack during ABORT is dropped
   // because routing happens in GRANT only; the abort err comes from the
   // registered pending flag.
   assign m_dat_o   = s_dat_i;
   assign m_ack_o   = (in_grant && s_ack_i) ? grant_q : '0;
   assign m_rty_o   = (in_grant && s_rty_i) ? grant_q : '0;
   assign m_err_o   = ((in_grant && s_err_i) ? grant_q : '0) |
                      (err_pend_q ? grant_q : '0);
   assign timeout_o = err_pend_q;
   assign grant_o   = grant_q;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      last_d     = last_q;
      wd_d       = wd_q;
      err_pend_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wd_d = '0;
            if (pick_vld) begin
               state_d        = ST_GRANT;
               owner_d        = pick;
               grant_d        = '0;
               grant_d[pick]  = 1'b1;
            end
         end
         ST_GRANT: begin
            if (!cyc_g) begin
               // Release, even with a strobe still pending.
               state_d = ST_IDLE;
               grant_d = '0;
               last_d  = owner_q;
               wd_d    = '0;
            end else if (!stb_g || term_any) begin
               // A termination on the expiry cycle wins over the abort.
               wd_d = '0;
            end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
               state_d    = ST_ABORT;
               err_pend_d = 1'b1;
               wd_d       = '0;
            end else if (TIMEOUT != 0) begin
               wd_d = wd_q + CW'(1);
            end
         end
         ST_ABORT: begin
            wd_d = '0;
            if (!cyc_g) begin
               state_d = ST_IDLE;
               grant_d = '0;
               last_d  = owner_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers. last_q resets to N-1 so master 0 wins first.
   // ------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         last_q     <= PW'(N - 1);
         wd_q       <= '0;
         err_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         wd_q       <= wd_d;
         err_pend_q <= err_pend_d;
      end
   end

endmodule
